// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter packing per-unit results into registered PRF/ROB write slots
//
// Claims up to wwd finished results per cycle across nfu functional units,
// packs them densely into a registered writeback bundle and squashes results
// younger than an active redirect. Unit priority rotates round-robin every
// non-held cycle so no unit can be starved.
//
// Optional build macro: WBARB_PERF_EN (enables the perf_stall counter).
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   redir      redirect bundle (opid = redirecting op, topid = oldest in-flight op)
//   hold       downstream stall: freeze output, issue no claims
//   resp_in    per-unit result lanes [nfu][ewd]; lane valid iff opid[15]
//   claim      per-unit per-lane claim (combinational), [unit][lane]
//   wb         registered writeback slots [wwd]; slot valid iff opid[15]
//   perf_stall cycles with a valid, non-squashed result left unclaimed

package wb_arbiter_pkg;

    typedef struct packed {
        logic [15:0] opid;
        logic [5:0]  prd;
        logic [63:0] data;
    } exe_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;

endpackage

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int nfu  = 2,
    parameter int ewd  = 4,
    parameter int wwd  = 4,
    parameter int opsz = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  red_bundle_t              redir,
    input  logic                     hold,
    input  exe_bundle_t              resp_in [nfu][ewd],
    output logic [nfu-1:0][ewd-1:0]  claim,
    output exe_bundle_t              wb [wwd],
    output logic [63:0]              perf_stall
);

    localparam int OW  = $clog2(opsz);
    localparam int RRW = (nfu > 1) ? $clog2(nfu) : 1;
    localparam int SW  = (wwd > 1) ? $clog2(wwd) : 1;

    localparam logic [RRW-1:0] RR_LAST = RRW'(nfu - 1);
    localparam logic [SW:0]    WWD_C   = (SW + 1)'(wwd);

    // Order arithmetic is modular in the OW-bit opid space; distances are
    // measured from the oldest in-flight op (topid), so wrap-around of the
    // opid counter is handled naturally.
    function automatic logic is_young(input logic [15:0] o, input red_bundle_t r);
        logic [OW-1:0] age;
        logic [OW-1:0] lim;
        age = o[OW-1:0] - r.topid[OW-1:0];
        lim = r.opid[OW-1:0] - r.topid[OW-1:0] + OW'(1);
        return r.opid[15] & o[15] & (age >= lim);
    endfunction

    logic [RRW-1:0]           rr_q, rr_d;
    exe_bundle_t              wb_q [wwd];
    exe_bundle_t              wb_d [wwd];
    exe_bundle_t              pack [wwd];
    logic [nfu-1:0][ewd-1:0]  claim_raw;

    // Only the low OW opid bits take part in order arithmetic.
    logic unused_redir;
    assign unused_redir = ^{redir.opid[14:OW], redir.topid[15:OW]};

    // Selection: scan units from rr, lanes in order. Young lanes are claimed
    // and dropped without consuming a slot. Once a valid lane of a unit fails
    // to get a slot, the rest of that unit is left alone because producers
    // only dequeue in-order prefixes.
    always_comb begin
        logic [SW:0] slot;
        logic        broken;
        int          u;
        claim_raw = '0;
        slot      = '0;
        broken    = 1'b0;
        u         = 0;
        for (int s = 0; s < wwd; s++) begin
            pack[s] = '0;
        end
        for (int k = 0; k < nfu; k++) begin
            u = int'(rr_q) + k;
            if (u >= nfu) begin
                u = u - nfu;
            end
            broken = 1'b0;
            for (int l = 0; l < ewd; l++) begin
                if (resp_in[u][l].opid[15]) begin
                    if (is_young(resp_in[u][l].opid, redir)) begin
                        claim_raw[u][l] = 1'b1;
                    end else if (!broken && (slot < WWD_C)) begin
                        claim_raw[u][l]    = 1'b1;
                        pack[slot[SW-1:0]] = resp_in[u][l];
                        slot               = slot + 1'b1;
                    end else begin
                        broken = 1'b1;
                    end
                end
            end
        end
    end

    assign claim = (rst || hold) ? '0 : claim_raw;

    // Next-state: a held bundle stays in place but still loses any slot the
    // current redirect squashes; otherwise load the freshly packed bundle.
    always_comb begin
        for (int s = 0; s < wwd; s++) begin
            wb_d[s] = pack[s];
            if (hold) begin
                wb_d[s] = is_young(wb_q[s].opid, redir) ? '0 : wb_q[s];
            end
        end
        rr_d = rr_q;
        if (!hold) begin
            rr_d = (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            for (int s = 0; s < wwd; s++) begin
                wb_q[s] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int s = 0; s < wwd; s++) begin
                wb_q[s] <= wb_d[s];
            end
        end
    end

    always_comb begin
        for (int s = 0; s < wwd; s++) begin
            wb[s] = wb_q[s];
        end
    end

`ifdef WBARB_PERF_EN
    logic [63:0] perf_q;
    logic        stall_any;

    // A stall cycle is one where some live (valid, not squashed) result was
    // offered but not taken, whether for lack of slots, a broken prefix or hold.
    always_comb begin
        stall_any = 1'b0;
        for (int u = 0; u < nfu; u++) begin
            for (int l = 0; l < ewd; l++) begin
                if (resp_in[u][l].opid[15] && !is_young(resp_in[u][l].opid, redir)
                    && !claim[u][l]) begin
                    stall_any = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall_any) begin
            perf_q <= perf_q + 64'd1;
        end
    end

    assign perf_stall = perf_q;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - table-driven scoreboard bench for wb_arbiter

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               hold;
    red_bundle_t        redir;
    exe_bundle_t        resp_in [2][4];
    logic [1:0][3:0]    claim;
    exe_bundle_t        wb [4];
    logic [63:0]        perf_stall;

    wb_arbiter #(.nfu(2), .ewd(4), .wwd(4), .opsz(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .redir      (redir),
        .hold       (hold),
        .resp_in    (resp_in),
        .claim      (claim),
        .wb         (wb),
        .perf_stall (perf_stall)
    );

    always #5 clk = ~clk;

    // ops index = unit*4 + lane; wb index = slot
    typedef logic [7:0][15:0] ops_t;
    typedef logic [3:0][15:0] wbv_t;

    typedef struct packed {
        ops_t        ops;
        logic [15:0] ropid;
        logic [15:0] rtopid;
        logic [7:0]  claim;
        wbv_t        wb;
        logic        stall;
    } vec_t;

    vec_t        vt [11];
    wbv_t        sb_q [$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_perf = '0;

    function automatic logic [63:0] dat(input logic [15:0] op);
        return {op, ~op, op ^ 16'h5a5a, 16'hc3c3};
    endfunction

    task automatic drive_ops(input ops_t o);
        for (int u = 0; u < 2; u++) begin
            for (int l = 0; l < 4; l++) begin
                resp_in[u][l].opid = o[u*4+l];
                resp_in[u][l].prd  = o[u*4+l][5:0];
                resp_in[u][l].data = dat(o[u*4+l]);
            end
        end
    endtask

    task automatic step(input ops_t o, input logic [15:0] ro, input logic [15:0] rt,
                        input logic h, input logic r, input logic [7:0] ec,
                        input wbv_t ew, input logic es, input string nm);
        wbv_t got_exp;
        wbv_t got;
        logic bad;
        rst   = r;
        hold  = h;
        redir = '{opid: ro, topid: rt};
        drive_ops(o);
        #1;
        checks++;
        if (claim !== ec) begin
            errors++;
            $display("FAIL %s claim: got %b want %b", nm, claim, ec);
        end
        sb_q.push_back(ew);
`ifdef WBARB_PERF_EN
        if (r) exp_perf = '0;
        else if (es) exp_perf = exp_perf + 64'd1;
`endif
        @(posedge clk);
        #1;
        got_exp = sb_q.pop_front();
        bad = 1'b0;
        for (int s = 0; s < 4; s++) begin
            got[s] = wb[s].opid;
            if (wb[s].opid !== got_exp[s]) bad = 1'b1;
            if (got_exp[s][15] && (wb[s].data !== dat(got_exp[s]) || wb[s].prd !== got_exp[s][5:0]))
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s wb: got %h want %h", nm, got, got_exp);
        end
        checks++;
        if (perf_stall !== exp_perf) begin
            errors++;
            $display("FAIL %s perf_stall: got %0d want %0d", nm, perf_stall, exp_perf);
        end
    endtask

    task automatic tv(input int i, input ops_t o, input logic [15:0] ro, input logic [15:0] rt,
                      input logic [7:0] c, input wbv_t w, input logic s);
        vt[i] = '{ops: o, ropid: ro, rtopid: rt, claim: c, wb: w, stall: s};
    endtask

    initial begin
        // ops written {u1l3,u1l2,u1l1,u1l0, u0l3,u0l2,u0l1,u0l0}; wb written {s3,s2,s1,s0}
        tv(0,  {16'h0, 16'h0, 16'h8005, 16'h8004, 16'h0, 16'h8003, 16'h8002, 16'h8001}, 16'h0, 16'h0,
               8'b0001_0111, {16'h8004, 16'h8003, 16'h8002, 16'h8001}, 1'b1);
        tv(1,  {16'h0, 16'h0, 16'h0, 16'h8005, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h0, 16'h0,
               8'b0001_0000, {16'h0, 16'h0, 16'h0, 16'h8005}, 1'b0);
        tv(2,  {16'h0, 16'h0, 16'h0, 16'h0, 16'h8013, 16'h8012, 16'h8011, 16'h0}, 16'h0, 16'h0,
               8'b0000_1110, {16'h0, 16'h8013, 16'h8012, 16'h8011}, 1'b0);
        tv(3,  {16'h0, 16'h8033, 16'h8032, 16'h8031, 16'h8024, 16'h8023, 16'h8022, 16'h8021}, 16'h0, 16'h0,
               8'b0111_0001, {16'h8021, 16'h8033, 16'h8032, 16'h8031}, 1'b1);
        tv(4,  {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8006, 16'h8004}, 16'h8005, 16'h8000,
               8'b0000_0011, {16'h0, 16'h0, 16'h0, 16'h8004}, 1'b0);
        tv(5,  {16'h0, 16'h8003, 16'h8002, 16'h8007, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h8005, 16'h8000,
               8'b0111_0000, {16'h0, 16'h0, 16'h8003, 16'h8002}, 1'b0);
        tv(6,  {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h803E, 16'h8001}, 16'h803F, 16'h803E,
               8'b0000_0011, {16'h0, 16'h0, 16'h0, 16'h803E}, 1'b0);
        tv(7,  {16'h8044, 16'h8043, 16'h8042, 16'h8041, 16'h0, 16'h8052, 16'h0, 16'h8051}, 16'h0, 16'h0,
               8'b1111_0000, {16'h8044, 16'h8043, 16'h8042, 16'h8041}, 1'b1);
        tv(8,  {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8006}, 16'h0005, 16'h8000,
               8'b0000_0001, {16'h0, 16'h0, 16'h0, 16'h8006}, 1'b0);
        tv(9,  '0, 16'h0, 16'h0, 8'b0000_0000, '0, 1'b0);
        tv(10, {16'h0, 16'h0, 16'h0, 16'h8071, 16'h8064, 16'h8063, 16'h8062, 16'h8061}, 16'h0, 16'h0,
               8'b0000_1111, {16'h8064, 16'h8063, 16'h8062, 16'h8061}, 1'b1);

        rst   = 1'b1;
        hold  = 1'b0;
        redir = '0;
        drive_ops({16'h0, 16'h0, 16'h0, 16'h8091, 16'h8084, 16'h8083, 16'h8082, 16'h8081});
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (claim !== 8'b0) begin
            errors++;
            $display("FAIL reset claim: got %b want 00000000", claim);
        end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (wb[s].opid !== 16'h0) begin
                errors++;
                $display("FAIL reset wb%0d: got %h want 0000", s, wb[s].opid);
            end
        end
        checks++;
        if (perf_stall !== 64'd0) begin
            errors++;
            $display("FAIL reset perf_stall: got %0d want 0", perf_stall);
        end

        for (int i = 0; i < 11; i++) begin
            step(vt[i].ops, vt[i].ropid, vt[i].rtopid, 1'b0, 1'b0, vt[i].claim,
                 vt[i].wb, vt[i].stall, $sformatf("vec%0d", i));
        end

        // Hold three cycles with live lanes: no claims, wb frozen, rr frozen at 1.
        for (int i = 0; i < 3; i++) begin
            step({16'h0, 16'h0, 16'h0, 16'h8091, 16'h8084, 16'h8083, 16'h8082, 16'h8081},
                 16'h0, 16'h0, 1'b1, 1'b0, 8'b0,
                 {16'h8064, 16'h8063, 16'h8062, 16'h8061}, 1'b1, $sformatf("hold%0d", i));
        end
        // Redirect during hold clears only the young held slots, without compaction.
        step('0, 16'h8062, 16'h8060, 1'b1, 1'b0, 8'b0,
             {16'h0, 16'h0, 16'h8062, 16'h8061}, 1'b0, "hold_redir");
        // Release: rr is still 1, so unit1 wins all four slots.
        step({16'h80B4, 16'h80B3, 16'h80B2, 16'h80B1, 16'h80A4, 16'h80A3, 16'h80A2, 16'h80A1},
             16'h0, 16'h0, 1'b0, 1'b0, 8'b1111_0000,
             {16'h80B4, 16'h80B3, 16'h80B2, 16'h80B1}, 1'b1, "release");
        // Reset while wb holds four valid slots.
        step({16'h80B4, 16'h80B3, 16'h80B2, 16'h80B1, 16'h80A4, 16'h80A3, 16'h80A2, 16'h80A1},
             16'h0, 16'h0, 1'b0, 1'b1, 8'b0, '0, 1'b0, "mid_reset");
        // rr back to 0 after reset: unit0 wins.
        step({16'h80B4, 16'h80B3, 16'h80B2, 16'h80B1, 16'h80A4, 16'h80A3, 16'h80A2, 16'h80A1},
             16'h0, 16'h0, 1'b0, 1'b0, 8'b0000_1111,
             {16'h80A4, 16'h80A3, 16'h80A2, 16'h80A1}, 1'b1, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
